// File: rtl/ntt_core_psi_adapter_if.sv
// Coefficient stream bundle: data word plus sideband and valid/ready handshake.
interface ntt_core_psi_adapter_if #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8
);
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
    logic              sob;
    logic              eob;
    logic              vld;
    logic              rdy;

    modport master (output data, output ctrl, output sob, output eob, output vld, input rdy);
    modport slave  (input data, input ctrl, input sob, input eob, input vld, output rdy);
endinterface

// File: rtl/ntt_core_psi_adapter.sv
// Width down-converter: splits each wide PSI_IN word into K = PSI_IN/PSI_OUT
// consecutive chunks, with a single holding register and zero-bubble reload.
module ntt_core_psi_adapter #(
    parameter int OP_W    = 64,
    parameter int R       = 2,
    parameter int PSI_IN  = 128,
    parameter int PSI_OUT = 32,
    parameter int CTRL_W  = 8
) (
    input  logic                     clk,
    input  logic                     a_rst,
    ntt_core_psi_adapter_if.slave    in_bus,
    ntt_core_psi_adapter_if.master   out_bus
);
    localparam int K       = PSI_IN / PSI_OUT;
    localparam int CHUNK_W = PSI_OUT * R * OP_W;
    localparam int CNT_W   = (K > 1) ? $clog2(K) : 1;

    generate
        if (PSI_OUT < 1 || (PSI_IN % PSI_OUT) != 0 || K < 1 || (K & (K - 1)) != 0) begin : g_bad_ratio
            $error("ntt_core_psi_adapter: PSI_IN/PSI_OUT must be a power of 2 >= 1");
        end
    endgenerate

    typedef enum logic {
        EMPTY,
        FULL
    } state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [K-1:0][CHUNK_W-1:0]  hold_data;
    logic [CTRL_W-1:0]          hold_ctrl;
    logic                       hold_sob;
    logic                       hold_eob;
    logic                       last_chunk;
    logic                       load;

    assign last_chunk = (cnt_q == CNT_W'(K - 1));

    // in_bus.rdy is derived from state, cnt and out_bus.rdy only, never from in_bus.vld.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        load        = 1'b0;
        in_bus.rdy  = 1'b0;
        out_bus.vld = 1'b0;
        case (state_q)
            EMPTY: begin
                in_bus.rdy = 1'b1;
                if (in_bus.vld) begin
                    load    = 1'b1;
                    state_d = FULL;
                    cnt_d   = '0;
                end
            end
            FULL: begin
                out_bus.vld = 1'b1;
                in_bus.rdy  = last_chunk & out_bus.rdy;
                if (out_bus.rdy) begin
                    if (!last_chunk) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else if (in_bus.vld) begin
                        load  = 1'b1;
                        cnt_d = '0;
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
            default: begin
                state_d = EMPTY;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            state_q <= EMPTY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            hold_data <= in_bus.data;
            hold_ctrl <= in_bus.ctrl;
            hold_sob  <= in_bus.sob;
            hold_eob  <= in_bus.eob;
        end
    end

    generate
        if (K == 1) begin : g_slice
            assign out_bus.data = hold_data[0];
        end else begin : g_split
            assign out_bus.data = hold_data[cnt_q];
        end
    endgenerate

    assign out_bus.ctrl = hold_ctrl;
    assign out_bus.sob  = (state_q == FULL) & hold_sob & (cnt_q == '0);
    assign out_bus.eob  = (state_q == FULL) & hold_eob & last_chunk;
endmodule

// File: tb/tb_ntt_core_psi_adapter.sv
// Bench for ntt_core_psi_adapter: a K=4 and a K=1 instance checked against a chunk-queue model.
module tb_ntt_core_psi_adapter;
    localparam int OP_W  = 64;
    localparam int CH_W  = 32 * 2 * OP_W;
    localparam int IN4_W = 128 * 2 * OP_W;
    localparam int IN1_W = 32 * 2 * OP_W;

    typedef logic [CH_W-1:0]  chunk_t;
    typedef logic [IN4_W-1:0] word_t;
    typedef struct {
        chunk_t     d;
        logic [7:0] c;
        logic       s;
        logic       e;
    } exp_t;

    logic clk = 1'b0;
    logic a_rst = 1'b1;
    always #5 clk = ~clk;

    ntt_core_psi_adapter_if #(.DATA_W(IN4_W), .CTRL_W(8)) i4 ();
    ntt_core_psi_adapter_if #(.DATA_W(CH_W),  .CTRL_W(8)) o4 ();
    ntt_core_psi_adapter_if #(.DATA_W(IN1_W), .CTRL_W(8)) i1 ();
    ntt_core_psi_adapter_if #(.DATA_W(CH_W),  .CTRL_W(8)) o1 ();

    ntt_core_psi_adapter #(.OP_W(64), .R(2), .PSI_IN(128), .PSI_OUT(32), .CTRL_W(8)) u_dut4 (
        .clk(clk), .a_rst(a_rst), .in_bus(i4), .out_bus(o4));
    ntt_core_psi_adapter #(.OP_W(64), .R(2), .PSI_IN(32), .PSI_OUT(32), .CTRL_W(8)) u_dut1 (
        .clk(clk), .a_rst(a_rst), .in_bus(i1), .out_bus(o1));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic       in_x[2];
    logic       out_x[2];
    word_t      win[2];
    logic [7:0] wc[2];
    logic       ws[2], we[2];
    logic       stall[2];
    chunk_t     pd[2];
    logic [7:0] pc[2];
    logic       ps[2], pe[2];
    int         ocnt[2];
    int         ofirst[2];
    int         olast[2];

    task automatic chk(input string nm, input int id, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t got %h expected %h", nm, id, $time, act, exp);
        end
    endtask

    task automatic chk_chunk(input string nm, input int id, input chunk_t act, input chunk_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            for (int j = 0; j < CH_W / OP_W; j++) begin
                if (act[j*OP_W +: OP_W] !== exp[j*OP_W +: OP_W]) begin
                    $display("FAIL %s dut%0d t=%0t coef %0d got %h expected %h", nm, id, $time, j,
                             act[j*OP_W +: OP_W], exp[j*OP_W +: OP_W]);
                    break;
                end
            end
        end
    endtask

    function automatic int qsize(input int id);
        return (id == 0) ? q0.size() : q1.size();
    endfunction

    // A word becomes K chunks, flags attached to the first / last chunk.
    task automatic model_push(input int id, input word_t w, input logic [7:0] c, input logic s, input logic e);
        int k;
        exp_t it;
        k = (id == 0) ? 4 : 1;
        for (int j = 0; j < k; j++) begin
            it.d = w[j*CH_W +: CH_W];
            it.c = c;
            it.s = s && (j == 0);
            it.e = e && (j == k - 1);
            if (id == 0) q0.push_back(it);
            else         q1.push_back(it);
        end
    endtask

    task automatic mon(input int id, input logic vld, input logic irdy, input logic ordy,
                       input chunk_t d, input logic [7:0] c, input logic s, input logic e);
        int n;
        exp_t f;
        if (a_rst) begin
            chk("vld_in_reset", id, 64'(vld), 64'(0));
            stall[id] = 1'b0;
            return;
        end
        n = qsize(id);
        chk("out_vld", id, 64'(vld), 64'(n > 0));
        chk("in_rdy", id, 64'(irdy), 64'((n == 0) || (n == 1 && ordy)));
        if (n > 0 && vld) begin
            f = (id == 0) ? q0[0] : q1[0];
            chk_chunk("out_data", id, d, f.d);
            chk("out_ctrl", id, 64'(c), 64'(f.c));
            chk("out_sob", id, 64'(s), 64'(f.s));
            chk("out_eob", id, 64'(e), 64'(f.e));
        end
        if (stall[id]) begin
            chk_chunk("stall_data", id, d, pd[id]);
            chk("stall_flags", id, {54'd0, c, s, e}, {54'd0, pc[id], ps[id], pe[id]});
        end
        stall[id] = vld && !ordy;
        pd[id] = d;
        pc[id] = c;
        ps[id] = s;
        pe[id] = e;
    endtask

    always @(negedge clk) begin
        mon(0, o4.vld, i4.rdy, o4.rdy, o4.data, o4.ctrl, o4.sob, o4.eob);
        mon(1, o1.vld, i1.rdy, o1.rdy, o1.data, o1.ctrl, o1.sob, o1.eob);
        in_x[0]  = !a_rst && i4.vld && i4.rdy;
        out_x[0] = !a_rst && o4.vld && o4.rdy;
        in_x[1]  = !a_rst && i1.vld && i1.rdy;
        out_x[1] = !a_rst && o1.vld && o1.rdy;
        win[0] = i4.data;
        wc[0] = i4.ctrl; ws[0] = i4.sob; we[0] = i4.eob;
        win[1] = IN4_W'(i1.data);
        wc[1] = i1.ctrl; ws[1] = i1.sob; we[1] = i1.eob;
    end

    always @(posedge clk) begin
        cyc++;
        if (!a_rst) begin
            for (int id = 0; id < 2; id++) begin
                if (out_x[id]) begin
                    if (ocnt[id] == 0) ofirst[id] = cyc;
                    olast[id] = cyc;
                    ocnt[id]++;
                    if (id == 0 && q0.size() > 0) void'(q0.pop_front());
                    if (id == 1 && q1.size() > 0) void'(q1.pop_front());
                end
                if (in_x[id]) model_push(id, win[id], wc[id], ws[id], we[id]);
            end
        end
    end

    function automatic word_t rand_word();
        word_t w;
        for (int i = 0; i < IN4_W / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic word_t ramp_word();
        word_t w;
        for (int i = 0; i < IN4_W / OP_W; i++) w[i*OP_W +: OP_W] = 64'(i);
        return w;
    endfunction

    task automatic set_in(input int id, input logic v, input word_t w, input logic [7:0] c,
                          input logic s, input logic e);
        if (id == 0) begin
            i4.vld = v; i4.data = w; i4.ctrl = c; i4.sob = s; i4.eob = e;
        end else begin
            i1.vld = v; i1.data = w[IN1_W-1:0]; i1.ctrl = c; i1.sob = s; i1.eob = e;
        end
    endtask

    task automatic set_vld(input int id, input logic v);
        if (id == 0) i4.vld = v;
        else         i1.vld = v;
    endtask

    task automatic set_rdy(input int id, input logic r);
        if (id == 0) o4.rdy = r;
        else         o1.rdy = r;
    endtask

    // rdy_mode 0: random out_rdy at rdy_pct; rdy_mode 1: toggle every cycle.
    task automatic run_traffic(input int id, input int nwords, input int vld_pct, input int rdy_mode,
                               input int rdy_pct, input int budget);
        int issued;
        int acc;
        int cycles;
        logic v;
        logic r;
        issued = 0; acc = 0; cycles = 0; v = 1'b0; r = 1'b0;
        ocnt[id] = 0;
        while (cycles < budget && !(acc == nwords && qsize(id) == 0)) begin
            @(posedge clk);
            if (in_x[id]) begin
                acc++;
                v = 1'b0;
            end
            #1;
            cycles++;
            if (!v && issued < nwords && $urandom_range(99) < vld_pct) begin
                v = 1'b1;
                issued++;
                set_in(id, 1'b1, rand_word(), 8'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1)));
            end else if (!v) begin
                set_vld(id, 1'b0);
            end
            if (rdy_mode == 1) r = !r;
            else               r = ($urandom_range(99) < rdy_pct);
            set_rdy(id, r);
        end
        chk("traffic_done", id, 64'(acc == nwords && qsize(id) == 0), 64'(1));
        set_vld(id, 1'b0);
        set_rdy(id, 1'b1);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog t=%0t got timeout expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        word_t  w;
        chunk_t d;
        for (int id = 0; id < 2; id++) begin
            stall[id] = 1'b0; ocnt[id] = 0; in_x[id] = 1'b0; out_x[id] = 1'b0;
        end
        set_in(0, 1'b0, '0, 8'h00, 1'b0, 1'b0);
        set_in(1, 1'b0, '0, 8'h00, 1'b0, 1'b0);
        o4.rdy = 1'b1;
        o1.rdy = 1'b1;
        #3;
        chk("rst_vld", 0, 64'(o4.vld), 64'(0));
        chk("rst_sob_eob", 0, 64'({o4.sob, o4.eob}), 64'(0));
        chk("rst_vld", 1, 64'(o1.vld), 64'(0));
        repeat (3) @(posedge clk);
        #1 a_rst = 1'b0;
        #1;
        chk("rdy_after_rst", 0, 64'(i4.rdy), 64'(1));
        chk("rdy_after_rst", 1, 64'(i1.rdy), 64'(1));

        // Ramp word: chunk c must carry coefficients 64c..64c+63.
        @(posedge clk); #1;
        set_in(0, 1'b1, ramp_word(), 8'h5A, 1'b1, 1'b1);
        @(posedge clk); #1;
        set_vld(0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            #1;
            d = o4.data;
            chk("ramp_vld", 0, 64'(o4.vld), 64'(1));
            chk("ramp_coef_lo", 0, d[63:0], 64'(64 * c));
            chk("ramp_coef_hi", 0, d[63*64 +: 64], 64'(64 * c + 63));
            chk("ramp_flags", 0, {48'd0, o4.ctrl, 6'd0, o4.sob, o4.eob},
                {48'd0, 8'h5A, 6'd0, 1'(c == 0), 1'(c == 3)});
            @(posedge clk); #1;
        end
        #1 chk("ramp_idle", 0, 64'(o4.vld), 64'(0));

        // Continuous input, out_rdy high: 32 chunks with no gap.
        run_traffic(0, 8, 100, 0, 100, 200);
        chk("burst_chunks", 0, 64'(ocnt[0]), 64'(32));
        chk("burst_span", 0, 64'(olast[0] - ofirst[0]), 64'(31));

        // Reset while the third chunk is presented.
        @(posedge clk); #1;
        w = rand_word();
        set_in(0, 1'b1, w, 8'hC3, 1'b1, 1'b1);
        @(posedge clk); #1;
        set_vld(0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk_chunk("pre_rst_chunk2", 0, o4.data, w[2*CH_W +: CH_W]);
        a_rst = 1'b1;
        q0.delete();
        q1.delete();
        #1;
        chk("async_rst_vld", 0, 64'(o4.vld), 64'(0));
        chk("async_rst_flags", 0, 64'({o4.sob, o4.eob}), 64'(0));
        @(posedge clk); #1;
        a_rst = 1'b0;
        #1 chk("rdy_after_rst2", 0, 64'(i4.rdy), 64'(1));
        @(posedge clk); #1;
        set_in(0, 1'b1, ramp_word(), 8'h11, 1'b1, 1'b0);
        @(posedge clk); #1;
        set_vld(0, 1'b0);
        #1;
        d = o4.data;
        chk("post_rst_first", 0, {d[63:0]}, 64'(0));
        chk("post_rst_sob", 0, 64'(o4.sob), 64'(1));
        repeat (6) @(posedge clk);

        // Random backpressure, 1000 words.
        run_traffic(0, 1000, 80, 0, 50, 40000);
        chk("rand_chunks", 0, 64'(ocnt[0]), 64'(4000));

        // K=1 slice with out_rdy toggling: one transfer every other cycle.
        run_traffic(1, 40, 100, 1, 0, 400);
        chk("k1_words", 1, 64'(ocnt[1]), 64'(40));
        chk("k1_span", 1, 64'(olast[1] - ofirst[1]), 64'(78));

        run_traffic(1, 200, 70, 0, 60, 4000);
        chk("k1_rand_words", 1, 64'(ocnt[1]), 64'(200));

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ntt_core_psi_adapter.md
NTT_CORE_PSI_ADAPTER -- requirements
Module: ntt_core_psi_adapter

Interface
REQ-001 Parameter OP_W, default 64: width of one NTT coefficient in bits.
REQ-002 Parameter R, default 2: radix; coefficients per butterfly.
REQ-003 Parameter PSI_IN, default 128: butterflies carried per input word.
REQ-004 Parameter PSI_OUT, default 32: butterflies carried per output word; PSI_IN/PSI_OUT = K, a power of 2 >= 1 (elaboration error otherwise).
REQ-005 Parameter CTRL_W, default 8: sideband control width.
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 a_rst  in  1  reset, asynchronous, active-high.
REQ-008 in_data  in  PSI_IN*R*OP_W  input coefficients; coefficient i at bits [i*OP_W +: OP_W].
REQ-009 in_ctrl  in  CTRL_W  sideband, held with the word.
REQ-010 in_sob  in  1  word is first of a batch.
REQ-011 in_eob  in  1  word is last of a batch.
REQ-012 in_vld  in  1  input valid.
REQ-013 in_rdy  out  1  input ready.
REQ-014 out_data  out  PSI_OUT*R*OP_W  output chunk.
REQ-015 out_ctrl  out  CTRL_W  sideband of the source word.
REQ-016 out_sob  out  1  first chunk of an in_sob word.
REQ-017 out_eob  out  1  last chunk of an in_eob word.
REQ-018 out_vld  out  1  output valid.
REQ-019 out_rdy  in  1  output ready.

Function
REQ-020 Transfers occur on vld&rdy, both ports; out_data/out_ctrl/out_sob/out_eob stable while out_vld=1 and out_rdy=0.
REQ-021 Each accepted input word emits exactly K output chunks, chunk c = coefficients [c*PSI_OUT*R, (c+1)*PSI_OUT*R), c ascending from 0.
REQ-022 FSM states: EMPTY (no held word), FULL (word held in register, chunk counter cnt in 0..K-1).
REQ-023 EMPTY: out_vld=0, in_rdy=1; on input transfer -> FULL, cnt=0.
REQ-024 FULL: out_vld=1, out_data = chunk cnt of held word.
REQ-025 FULL, output transfer with cnt<K-1: cnt increments, in_rdy=0 that cycle.
REQ-026 FULL, cnt=K-1: in_rdy = out_rdy (combinational); simultaneous input and output transfer loads new word, cnt=0, stays FULL (zero bubbles); output transfer without input -> EMPTY.
REQ-027 in_rdy depends only on state, cnt, out_rdy; never on in_vld.
REQ-028 out_sob = held sob AND cnt=0; out_eob = held eob AND cnt=K-1; out_ctrl = held ctrl for all K chunks.
REQ-029 K=1: register slice, one chunk per word, full throughput, out_sob/out_eob = held flags.
REQ-030 Latency: first chunk valid the cycle after input transfer; sustained throughput 1 output chunk per cycle when out_rdy=1 and in_vld=1.
REQ-031 cnt width max(1,log2(K)); wrap only via REQ-026, never overflows.
REQ-032 Data paths unregistered beyond the single holding register; no arithmetic on coefficients.

Reset
REQ-033 On a_rst=1, immediately: state EMPTY, cnt=0, out_vld=0, out_sob=0, out_eob=0; in_rdy=1 after deassert.
REQ-034 Reset mid-word discards held word; no partial chunks emitted after reset.
REQ-035 Holding data/ctrl registers need no reset; outputs gated by out_vld only.

Verification
REQ-036 K=4, PSI_OUT=32, OP_W=64, out_rdy=1, one word (coef i = i, sob=1, eob=1, ctrl=0x5A) -> 4 chunks on consecutive cycles starting next cycle, chunk c holds values 64c..64c+63, sob on chunk 0 only, eob on chunk 3 only, ctrl 0x5A on all.
REQ-037 K=4, in_vld=1 continuously, out_rdy=1, 8 words -> 32 chunks back-to-back, no out_vld gap, in_rdy high only on cnt=3 cycles.
REQ-038 K=4, random out_rdy (50%) -> out_data stable while stalled; chunk sequence equals reference model; no loss or duplication over 1000 words.
REQ-039 a_rst asserted while cnt=2 -> out_vld=0 in same cycle (async); after release next word's chunk 0 emitted first, no remnant chunks.
REQ-040 K=1 (PSI_IN=PSI_OUT=32), continuous traffic with out_rdy toggling every cycle -> each word emitted once, sob/eob passed unchanged, throughput equals out_rdy duty.
